// File: rtl/apb_master_bridge_if.sv
// APB bus bundle between the bridge (master) and an APB slave.
//   paddr, pwdata          : address / write data driven by the master
//   psel, penable, pwrite  : APB control, driven by the master
//   prdata, pready, pslverr: slave response
`timescale 1ns/1ps
interface apb_master_bridge_if;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output paddr, pwdata, psel, penable, pwrite,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, pwdata, psel, penable, pwrite,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-request core bus to APB master bridge.
// Accepts one core request in IDLE, runs one APB SETUP/ACCESS transfer, and
// returns a one-cycle bus_ready pulse (qualified by bus_err) from RESP.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   bus_addr/bus_wdata/bus_write: core request fields, sampled on acceptance
//   bus_valid                   : core request strobe
//   bus_rdata                   : registered read data, held until next read completes
//   bus_ready, bus_err          : completion pulse and error qualifier
//   apb                         : APB master side of the bus bundle
// Parameters:
//   TIMEOUT   : ACCESS cycles allowed before abort (2..255)
//   ERR_RDATA : read data returned on slave error or timeout
`timescale 1ns/1ps
module apb_master_bridge #(
   parameter int unsigned TIMEOUT   = 16,
   parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                bus_addr,
   input  logic [31:0]                bus_wdata,
   input  logic                       bus_write,
   input  logic                       bus_valid,
   output logic [31:0]                bus_rdata,
   output logic                       bus_ready,
   output logic                       bus_err,
   apb_master_bridge_if.master        apb
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic        err_q, err_d;
   logic        psel_q, psel_d;
   logic        penable_q, penable_d;
   logic        pwrite_q, pwrite_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        berr_q, berr_d;

   // APB and core outputs are all registered; their _d values are decoded
   // from the state being entered, so each output lines up with its state.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      err_d     = err_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      rdata_d   = rdata_q;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      ready_d   = 1'b0;
      berr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus_valid) begin
               paddr_d  = bus_addr;
               pwdata_d = bus_wdata;
               pwrite_d = bus_write;
               wait_d   = 8'd0;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (apb.pready) begin
               err_d   = apb.pslverr;
               if (!pwrite_q) rdata_d = apb.pslverr ? ERR_RDATA : apb.prdata;
               ready_d = 1'b1;
               berr_d  = apb.pslverr;
               state_d = RESP;
            end else if (wait_q == WAIT_LAST) begin
               // slave never answered: abort the transfer as an error
               err_d   = 1'b1;
               if (!pwrite_q) rdata_d = ERR_RDATA;
               ready_d = 1'b1;
               berr_d  = 1'b1;
               state_d = RESP;
            end else begin
               wait_d    = wait_q + 8'd1;
               psel_d    = 1'b1;
               penable_d = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wait_q    <= 8'd0;
         err_q     <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= 32'd0;
         pwdata_q  <= 32'd0;
         rdata_q   <= 32'd0;
         ready_q   <= 1'b0;
         berr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         err_q     <= err_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         rdata_q   <= rdata_d;
         ready_q   <= ready_d;
         berr_q    <= berr_d;
      end
   end

   assign apb.paddr   = paddr_q;
   assign apb.pwdata  = pwdata_q;
   assign apb.psel    = psel_q;
   assign apb.penable = penable_q;
   assign apb.pwrite  = pwrite_q;
   assign bus_rdata   = rdata_q;
   assign bus_ready   = ready_q;
   assign bus_err     = berr_q;

endmodule
